alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO depth; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_a, cmd_b  input  8 each  operands.
REQ-007 cmd_op  input  3  opcode, ALU encoding (000 NOT A, 001 OR, 010 XOR, 011 AND, 100 MUL, 101 ADD, 110 SUB, 111 zero).
REQ-008 alu_a, alu_b  output  8 each  registered operands to the ALU.
REQ-009 alu_op  output  3  registered opcode to the ALU.
REQ-010 alu_out  input  8  combinational ALU result.
REQ-011 res_valid  output  1  result present.
REQ-012 res_ready  input  1  downstream accepts result.
REQ-013 res_data  output  8  captured result.
REQ-014 res_op  output  3  opcode that produced res_data.
REQ-015 fifo_count  output  log2(DEPTH)+1  commands queued, excluding the one in EXEC/DONE.

Function
REQ-016 A command SHALL be pushed on an edge where cmd_valid and cmd_ready are both 1.
REQ-017 cmd_ready SHALL be 1 exactly when fifo_count < DEPTH, with no dependence on a same-cycle pop; a full FIFO SHALL refuse a push even while popping.
REQ-018 FSM states SHALL be IDLE, EXEC and DONE.
REQ-019 IDLE with fifo_count > 0: pop the head into alu_a/alu_b/alu_op and go to EXEC.
REQ-020 EXEC: capture alu_out into res_data and alu_op into res_op, then go to DONE; EXEC SHALL last exactly one cycle.
REQ-021 DONE: res_valid = 1.
REQ-022 DONE with res_ready = 1 and fifo_count > 0: pop the next command into the alu_* registers and go to EXEC.
REQ-023 DONE with res_ready = 1 and fifo_count = 0: go to IDLE.
REQ-024 DONE with res_ready = 0: hold, and res_data, res_op and res_valid SHALL remain stable.
REQ-025 res_valid SHALL be 1 only in DONE.
REQ-026 alu_a, alu_b and alu_op SHALL change only on a pop; outside a pop they hold their last values.
REQ-027 Latency: a command pushed at edge N into an empty block in IDLE SHALL appear on alu_* after edge N+1 and assert res_valid after edge N+2.
REQ-028 Peak throughput SHALL be one result per two cycles.
REQ-029 A push and a pop on the same edge SHALL leave fifo_count unchanged.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH.
REQ-031 Results SHALL leave in command order; no command SHALL be dropped or duplicated.
REQ-032 res_data SHALL be alu_out unchanged (8-bit, already truncated by the ALU); no widening or sign handling.

Reset
REQ-033 While rst_n = 0, the FSM SHALL be IDLE, FIFO pointers and fifo_count 0, alu_a/alu_b 8'h00, alu_op 3'b000, res_data 8'h00, res_op 3'b000, res_valid 0; cmd_ready SHALL be 1 only after release.
REQ-034 Reset asserted mid-operation SHALL discard all queued and in-flight commands with no result emitted.
REQ-035 The first push SHALL be accepted on the first edge after rst_n rises.

Configuration
REQ-036 With ALU_ILLEGAL_OP_EN defined, output res_err (1 bit) SHALL exist; it equals 1 with res_valid for a result whose res_op = 3'b111, res_data is then 8'h00, and res_err resets to 0.
REQ-037 With ALU_ILLEGAL_OP_EN undefined, res_err SHALL be absent and opcode 111 SHALL be processed like any other opcode.

Verification
REQ-038 Push A=F0, B=20, op=101 with res_ready = 1 -> res_valid 2 cycles after acceptance, res_data = 10, res_op = 101.
REQ-039 Push 05/07/110, then 10/10/100, then AA/0F/000 with res_ready = 1 -> results FE, 00, 55 in that order, 2 cycles apart.
REQ-040 Hold res_ready = 0 and push 6 commands with DEPTH = 4 -> 1 command in DONE, 4 in the FIFO, cmd_ready = 0 after the 5th push, res_data stable; release res_ready -> all 5 results drain in order.
REQ-041 Macro defined, push 12/34/111 -> res_data = 00, res_err = 1; next command 12/34/001 -> res_data = 36, res_err = 0.
REQ-042 Pull rst_n low while in EXEC with 2 commands queued -> all outputs at reset values immediately; after release, no stale result appears.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Command/ALU/result signal bundle for alu_issue_ctrl.
// ALU_ILLEGAL_OP_EN adds the res_err result flag.
interface alu_issue_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_a;
    logic [7:0]    cmd_b;
    logic [2:0]    cmd_op;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [2:0]    alu_op;
    logic [7:0]    alu_out;
    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_data;
    logic [2:0]    res_op;
    logic [CW-1:0] fifo_count;
`ifdef ALU_ILLEGAL_OP_EN
    logic          res_err;
`endif

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op, fifo_count
`ifdef ALU_ILLEGAL_OP_EN
        , output res_err
`endif
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op, fifo_count
`ifdef ALU_ILLEGAL_OP_EN
        , input res_err
`endif
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Queues ALU commands in a FIFO and sequences them through an external ALU.
// ALU_ILLEGAL_OP_EN: flag opcode 111 results via res_err and force res_data to zero.
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_issue_ctrl: DEPTH must be a power of two between 2 and 16");
    end

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [18:0]   mem_q [DEPTH];
    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [7:0]    res_data_q, res_data_d;
    logic [2:0]    res_op_q, res_op_d;
    logic          cmd_ready;
    logic          push;
    logic          pop;
    logic [18:0]   head;

    // Readiness depends only on occupancy, so a full FIFO refuses even while popping.
    assign cmd_ready = rst_n && (count_q < CW'(DEPTH));
    assign push      = bus.cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];

`ifdef ALU_ILLEGAL_OP_EN
    logic res_err_q, res_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
        res_op_d   = res_op_q;
        pop        = 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
        res_err_d  = res_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_op_d   = alu_op_q;
                res_data_d = bus.alu_out;
`ifdef ALU_ILLEGAL_OP_EN
                res_err_d  = (alu_op_q == 3'b111);
                if (alu_op_q == 3'b111) res_data_d = '0;
`endif
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            {alu_op_d, alu_a_d, alu_b_d} = head;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_data_q <= '0;
            res_op_q   <= '0;
`ifdef ALU_ILLEGAL_OP_EN
            res_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_data_q <= res_data_d;
            res_op_q   <= res_op_d;
`ifdef ALU_ILLEGAL_OP_EN
            res_err_q  <= res_err_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read below the write pointer.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.res_valid  = (state_q == S_DONE);
    assign bus.res_data   = res_data_q;
    assign bus.res_op     = res_op_q;
    assign bus.fifo_count = count_q;
`ifdef ALU_ILLEGAL_OP_EN
    assign bus.res_err    = res_err_q && (state_q == S_DONE);
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU.
module tb_alu_issue_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_issue_ctrl_if #(.DEPTH(4)) bus ();

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External ALU the block drives.
    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_out = ~bus.alu_a;
            3'b001:  bus.alu_out = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'b011:  bus.alu_out = bus.alu_a & bus.alu_b;
            3'b100:  bus.alu_out = bus.alu_a * bus.alu_b;
            3'b101:  bus.alu_out = bus.alu_a + bus.alu_b;
            3'b110:  bus.alu_out = bus.alu_a - bus.alu_b;
            default: bus.alu_out = 8'h00;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    logic [7:0] bp_exp [5] = '{8'h03, 8'h00, 8'hFF, 8'h33, 8'h0F};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b exp 0", bus.cmd_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b exp 0", bus.res_valid); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", bus.fifo_count); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 19'h0) begin errors++; $display("FAIL rst_alu: got %h/%h/%b exp 00/00/000", bus.alu_a, bus.alu_b, bus.alu_op); end
        checks++; if ({bus.res_data, bus.res_op} !== 11'h0) begin errors++; $display("FAIL rst_res: got %h/%b exp 00/000", bus.res_data, bus.res_op); end
`ifdef ALU_ILLEGAL_OP_EN
        checks++; if (bus.res_err !== 1'b0) begin errors++; $display("FAIL rst_res_err: got %b exp 0", bus.res_err); end
`endif
        rst_n = 1'b1;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_cmd_ready: got %b exp 1", bus.cmd_ready); end
    endtask

    task automatic test_single();
        bus.res_ready = 1'b1;
        drive(8'hF0, 8'h20, 3'b101);
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL single_first_push: count got %0d exp 1", bus.fifo_count); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid0: got %b exp 0", bus.res_valid); end
        tick();
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {8'hF0, 8'h20, 3'b101}) begin errors++; $display("FAIL single_alu_regs: got %h/%h/%b exp f0/20/101", bus.alu_a, bus.alu_b, bus.alu_op); end
        checks++; if (bus.res_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL single_exec: valid %b count %0d exp 0/0", bus.res_valid, bus.fifo_count); end
        tick();
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", bus.res_valid); end
        checks++; if (bus.res_data !== 8'h10 || bus.res_op !== 3'b101) begin errors++; $display("FAIL single_result: got %h/%b exp 10/101", bus.res_data, bus.res_op); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_to_idle: valid got %b exp 0", bus.res_valid); end
    endtask

    task automatic test_back_to_back();
        bus.res_ready = 1'b1;
        drive(8'h05, 8'h07, 3'b110);
        tick();
        drive(8'h10, 8'h10, 3'b100);
        tick();
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_push_pop_count: got %0d exp 1", bus.fifo_count); end
        drive(8'hAA, 8'h0F, 3'b000);
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'hFE || bus.res_op !== 3'b110) begin errors++; $display("FAIL b2b_res0: got v%b %h/%b exp v1 fe/110", bus.res_valid, bus.res_data, bus.res_op); end
        checks++; if (bus.cmd_ready !== 1'b1 || bus.fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_queue: ready %b count %0d exp 1/2", bus.cmd_ready, bus.fifo_count); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap0: valid got %b exp 0", bus.res_valid); end
        tick();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h00 || bus.res_op !== 3'b100) begin errors++; $display("FAIL b2b_res1: got v%b %h/%b exp v1 00/100", bus.res_valid, bus.res_data, bus.res_op); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap1: valid got %b exp 0", bus.res_valid); end
        tick();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h55 || bus.res_op !== 3'b000) begin errors++; $display("FAIL b2b_res2: got v%b %h/%b exp v1 55/000", bus.res_valid, bus.res_data, bus.res_op); end
        tick();
        checks++; if (bus.res_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_end: valid %b count %0d exp 0/0", bus.res_valid, bus.fifo_count); end
    endtask

    task automatic test_backpressure();
        int n;
        bus.res_ready = 1'b0;
        drive(8'h01, 8'h02, 3'b101);
        tick();
        drive(8'hFF, 8'h01, 3'b101);
        tick();
        drive(8'h0F, 8'hF0, 3'b001);
        tick();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h03) begin errors++; $display("FAIL bp_first_result: got v%b %h exp v1 03", bus.res_valid, bus.res_data); end
        drive(8'h3C, 8'h0F, 3'b010);
        tick();
        drive(8'h03, 8'h05, 3'b100);
        tick();
        checks++; if (bus.fifo_count !== 3'd4 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full: count %0d ready %b exp 4/0", bus.fifo_count, bus.cmd_ready); end
        drive(8'hAA, 8'h55, 3'b011);
        tick();
        checks++; if (bus.fifo_count !== 3'd4 || bus.res_valid !== 1'b1 || bus.res_data !== 8'h03) begin errors++; $display("FAIL bp_refuse: count %0d v%b data %h exp 4/1/03", bus.fifo_count, bus.res_valid, bus.res_data); end
        tick();
        checks++; if (bus.res_data !== 8'h03 || bus.res_op !== 3'b101 || bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_stable: got v%b %h/%b exp v1 03/101", bus.res_valid, bus.res_data, bus.res_op); end
        bus.res_ready = 1'b1;
        n = 0;
        checks++; if (bus.res_data !== bp_exp[0]) begin errors++; $display("FAIL bp_drain0: got %h exp %h", bus.res_data, bp_exp[0]); end
        n = 1;
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd3 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_full_pop_no_push: count %0d v%b exp 3/0", bus.fifo_count, bus.res_valid); end
        for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
            if (bus.res_valid === 1'b1) begin
                checks++; if (bus.res_data !== bp_exp[n]) begin errors++; $display("FAIL bp_drain%0d: got %h exp %h", n, bus.res_data, bp_exp[n]); end
                n++;
            end
            tick();
        end
        checks++; if (n != 5) begin errors++; $display("FAIL bp_drain_count: got %0d exp 5", n); end
        tick();
        tick();
        checks++; if (bus.res_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL bp_no_extra: v%b count %0d exp 0/0", bus.res_valid, bus.fifo_count); end
    endtask

    task automatic test_op7();
        bus.res_ready = 1'b1;
        drive(8'h12, 8'h34, 3'b111);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h00 || bus.res_op !== 3'b111) begin errors++; $display("FAIL op7_result: got v%b %h/%b exp v1 00/111", bus.res_valid, bus.res_data, bus.res_op); end
`ifdef ALU_ILLEGAL_OP_EN
        checks++; if (bus.res_err !== 1'b1) begin errors++; $display("FAIL op7_err: got %b exp 1", bus.res_err); end
`endif
        tick();
        drive(8'h12, 8'h34, 3'b001);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h36 || bus.res_op !== 3'b001) begin errors++; $display("FAIL op1_result: got v%b %h/%b exp v1 36/001", bus.res_valid, bus.res_data, bus.res_op); end
`ifdef ALU_ILLEGAL_OP_EN
        checks++; if (bus.res_err !== 1'b0) begin errors++; $display("FAIL op1_err: got %b exp 0", bus.res_err); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        bus.res_ready = 1'b1;
        drive(8'h01, 8'h01, 3'b101);
        tick();
        drive(8'h02, 8'h02, 3'b101);
        tick();
        drive(8'h03, 8'h03, 3'b101);
        tick();
        drive(8'h04, 8'h04, 3'b101);
        tick();
        bus.cmd_valid = 1'b0;
        checks++; if (bus.res_valid !== 1'b0 || bus.fifo_count !== 3'd2 || bus.alu_a !== 8'h02) begin errors++; $display("FAIL mid_exec_setup: v%b count %0d alu_a %h exp 0/2/02", bus.res_valid, bus.fifo_count, bus.alu_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fifo_count !== 3'd0 || bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: count %0d ready %b v%b exp 0/0/0", bus.fifo_count, bus.cmd_ready, bus.res_valid); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.res_data, bus.res_op} !== 30'h0) begin errors++; $display("FAIL mid_rst_data: alu %h/%h/%b res %h/%b exp zeros", bus.alu_a, bus.alu_b, bus.alu_op, bus.res_data, bus.res_op); end
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            checks++; if (bus.res_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin errors++; $display("FAIL mid_stale%0d: v%b count %0d exp 0/0", cyc, bus.res_valid, bus.fifo_count); end
        end
        drive(8'h09, 8'h03, 3'b110);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h06 || bus.res_op !== 3'b110) begin errors++; $display("FAIL mid_after_rst: got v%b %h/%b exp v1 06/110", bus.res_valid, bus.res_data, bus.res_op); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_op7();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
